// File: rtl/heading_pkg.sv
// Shared definitions for the heading filter slice: cardinal codes, sector
// boundaries and FSM state encoding.
package heading_pkg;

  typedef enum logic [2:0] {
    CARD_N  = 3'd0,
    CARD_NE = 3'd1,
    CARD_E  = 3'd2,
    CARD_SE = 3'd3,
    CARD_S  = 3'd4,
    CARD_SW = 3'd5,
    CARD_W  = 3'd6,
    CARD_NW = 3'd7
  } cardinal_e;

  localparam logic [8:0] DEG_FULL = 9'd360;

  // Lower bound (inclusive) of each sector; SECT_N_HI reopens north.
  localparam logic [8:0] SECT_NE   = 9'd23;
  localparam logic [8:0] SECT_E    = 9'd68;
  localparam logic [8:0] SECT_SE   = 9'd113;
  localparam logic [8:0] SECT_S    = 9'd158;
  localparam logic [8:0] SECT_SW   = 9'd203;
  localparam logic [8:0] SECT_W    = 9'd248;
  localparam logic [8:0] SECT_NW   = 9'd293;
  localparam logic [8:0] SECT_N_HI = 9'd338;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_TRACK  = 2'd1,
    ST_CALC   = 2'd2,
    ST_UPDATE = 2'd3
  } state_e;

endpackage

// File: rtl/heading_to_cardinal.sv
// Combinational map from a 0-359 degree heading to an 8-point cardinal code.
module heading_to_cardinal
  import heading_pkg::*;
(
  input  logic [8:0] heading,
  output logic [2:0] cardinal
);

  cardinal_e code;

  always_comb begin
    if (heading < SECT_NE || heading >= SECT_N_HI) code = CARD_N;
    else if (heading < SECT_E)                     code = CARD_NE;
    else if (heading < SECT_SE)                    code = CARD_E;
    else if (heading < SECT_S)                     code = CARD_SE;
    else if (heading < SECT_SW)                    code = CARD_S;
    else if (heading < SECT_W)                     code = CARD_SW;
    else if (heading < SECT_NW)                    code = CARD_W;
    else                                           code = CARD_NW;
  end

  assign cardinal = code;

endmodule

// File: rtl/heading_filter.sv
// Wrap-aware fixed-point EMA on raw headings, with cardinal code, settled and
// stale-data flags for the display path.
module heading_filter
  import heading_pkg::*;
#(
  parameter int unsigned SHIFT          = 2,
  parameter int unsigned FRAC           = 4,
  parameter int unsigned SETTLE_TOL     = 5,
  parameter int unsigned SETTLE_COUNT   = 8,
  parameter int unsigned TIMEOUT_CYCLES = 4000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] heading_in,
  input  logic       heading_valid,
  output logic [8:0] heading_out,
  output logic [2:0] cardinal,
  output logic       out_valid,
  output logic       settled,
  output logic       stale,
  output logic       overrun
);

  localparam int unsigned FW = FRAC + 9;
  localparam int unsigned DW = FRAC + 10;
  localparam int unsigned SW = DW + 1;
  localparam int unsigned CW = $clog2(SETTLE_COUNT + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic signed [DW-1:0] FULL     = DW'(int'(DEG_FULL) << FRAC);
  localparam logic signed [DW-1:0] HALF     = FULL >>> 1;
  localparam logic signed [DW-1:0] TOL      = DW'(SETTLE_TOL << FRAC);
  localparam logic        [FW:0]   RND_HALF = (FW+1)'(1 << (FRAC - 1));
  localparam logic        [CW-1:0] CNT_MAX  = CW'(SETTLE_COUNT);
  localparam logic        [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic        [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);

  state_e                state_q, state_d;
  logic                  load_q, load_d;
  logic        [FW-1:0]  h_q, h_d;
  logic        [FW-1:0]  f_q, f_d;
  logic signed [DW-1:0]  diff_q, diff_d;
  logic        [8:0]     heading_q, heading_d;
  logic        [2:0]     card_q, card_d;
  logic                  out_valid_q, out_valid_d;
  logic                  settled_q, settled_d;
  logic                  stale_q, stale_d;
  logic                  overrun_q, overrun_d;
  logic        [CW-1:0]  settle_cnt_q, settle_cnt_d;
  logic        [TW-1:0]  tmo_cnt_q, tmo_cnt_d;

  logic                  busy, accept, timeout_hit;
  logic signed [DW-1:0]  diff_raw, diff_w, step;
  logic signed [SW-1:0]  f_sum;
  logic        [FW-1:0]  f_new;
  logic        [FW:0]    rnd;
  logic        [9:0]     hdg_round;
  logic                  in_tol;

  assign busy        = (state_q == ST_CALC) || (state_q == ST_UPDATE);
  assign accept      = heading_valid && (heading_in < DEG_FULL) && !busy;
  assign timeout_hit = !accept && (tmo_cnt_q == TMO_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_EMPTY;
      load_q       <= 1'b0;
      h_q          <= '0;
      f_q          <= '0;
      diff_q       <= '0;
      heading_q    <= '0;
      card_q       <= '0;
      out_valid_q  <= 1'b0;
      settled_q    <= 1'b0;
      stale_q      <= 1'b1;
      overrun_q    <= 1'b0;
      settle_cnt_q <= '0;
      tmo_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      load_q       <= load_d;
      h_q          <= h_d;
      f_q          <= f_d;
      diff_q       <= diff_d;
      heading_q    <= heading_d;
      card_q       <= card_d;
      out_valid_q  <= out_valid_d;
      settled_q    <= settled_d;
      stale_q      <= stale_d;
      overrun_q    <= overrun_d;
      settle_cnt_q <= settle_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    load_d  = load_q;
    case (state_q)
      ST_EMPTY, ST_TRACK: begin
        if (accept) begin
          state_d = ST_CALC;
          load_d  = (state_q == ST_EMPTY);
        end else if (timeout_hit) begin
          state_d = ST_EMPTY;
        end
      end
      ST_CALC:   state_d = ST_UPDATE;
      ST_UPDATE: state_d = ST_TRACK;
      default:   state_d = ST_EMPTY;
    endcase
  end

  // Shortest-path error: an exact 180 degree difference resolves positive.
  always_comb begin
    diff_raw = DW'(h_q) - DW'(f_q);
    diff_w   = diff_raw;
    if (diff_raw > HALF)       diff_w = diff_raw - FULL;
    else if (diff_raw <= -HALF) diff_w = diff_raw + FULL;

    step  = load_q ? diff_q : (diff_q >>> SHIFT);
    f_sum = $signed({2'b00, f_q}) + $signed({step[DW-1], step});
    if (f_sum < 0)         f_sum = f_sum + SW'(FULL);
    else if (f_sum >= FULL) f_sum = f_sum - SW'(FULL);
    f_new     = FW'(f_sum);
    rnd       = {1'b0, f_new} + RND_HALF;
    hdg_round = 10'(rnd >> FRAC);
    in_tol    = (diff_q <= TOL) && (diff_q >= -TOL);
  end

  always_comb begin
    h_d          = h_q;
    f_d          = f_q;
    diff_d       = diff_q;
    heading_d    = heading_q;
    out_valid_d  = 1'b0;
    settled_d    = settled_q;
    stale_d      = stale_q;
    settle_cnt_d = settle_cnt_q;
    overrun_d    = overrun_q | (heading_valid && busy);
    if (accept)                   tmo_cnt_d = '0;
    else if (tmo_cnt_q == TMO_MAX) tmo_cnt_d = tmo_cnt_q;
    else                          tmo_cnt_d = tmo_cnt_q + 1'b1;

    if (accept) h_d = {heading_in, {FRAC{1'b0}}};

    if (state_q == ST_CALC) diff_d = diff_w;

    if (state_q == ST_UPDATE) begin
      f_d         = f_new;
      heading_d   = (hdg_round == 10'(DEG_FULL)) ? '0 : 9'(hdg_round);
      out_valid_d = 1'b1;
      stale_d     = 1'b0;
      if (!load_q && in_tol)
        settle_cnt_d = (settle_cnt_q == CNT_MAX) ? settle_cnt_q : settle_cnt_q + 1'b1;
      else
        settle_cnt_d = '0;
      settled_d = (settle_cnt_d == CNT_MAX);
    end

    if (timeout_hit) begin
      stale_d      = 1'b1;
      settled_d    = 1'b0;
      settle_cnt_d = '0;
    end
  end

  heading_to_cardinal u_card (
    .heading  (heading_d),
    .cardinal (card_d)
  );

  assign heading_out = heading_q;
  assign cardinal    = card_q;
  assign out_valid   = out_valid_q;
  assign settled     = settled_q;
  assign stale       = stale_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_heading_filter.sv
// Directed bench for heading_filter with hand-computed expected headings.
module tb_heading_filter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [8:0] heading_in = '0;
  logic       heading_valid = 1'b0;
  logic [8:0] heading_out;
  logic [2:0] cardinal;
  logic       out_valid, settled, stale, overrun;

  int n_cmp = 0;
  int n_bad = 0;
  int lat;
  int pulses;

  heading_filter #(.TIMEOUT_CYCLES(100)) dut (
    .clk           (clk),
    .reset         (reset),
    .heading_in    (heading_in),
    .heading_valid (heading_valid),
    .heading_out   (heading_out),
    .cardinal      (cardinal),
    .out_valid     (out_valid),
    .settled       (settled),
    .stale         (stale),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic do_reset();
    reset = 1'b1;
    heading_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Drives one sample for one cycle; lat = edges from acceptance to out_valid (99 = none).
  task automatic send(input logic [8:0] h, output int l);
    heading_in = h;
    heading_valid = 1'b1;
    @(negedge clk);
    heading_valid = 1'b0;
    l = 99;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (out_valid) begin
        l = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (heading_out !== 9'd0) begin n_bad++; $display("FAIL reset_heading: got %0d expected 0", heading_out); end
    n_cmp++; if (cardinal !== 3'd0) begin n_bad++; $display("FAIL reset_cardinal: got %0d expected 0", cardinal); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (settled !== 1'b0) begin n_bad++; $display("FAIL reset_settled: got %b expected 0", settled); end
    n_cmp++; if (stale !== 1'b1) begin n_bad++; $display("FAIL reset_stale: got %b expected 1", stale); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_first_sample();
    send(9'd90, lat);
    n_cmp++; if (lat != 2) begin n_bad++; $display("FAIL first_latency: got %0d expected 2", lat); end
    n_cmp++; if (heading_out !== 9'd90) begin n_bad++; $display("FAIL first_heading: got %0d expected 90", heading_out); end
    n_cmp++; if (cardinal !== 3'd2) begin n_bad++; $display("FAIL first_cardinal: got %0d expected 2", cardinal); end
    n_cmp++; if (stale !== 1'b0) begin n_bad++; $display("FAIL first_stale: got %b expected 0", stale); end
    n_cmp++; if (settled !== 1'b0) begin n_bad++; $display("FAIL first_settled: got %b expected 0", settled); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL first_pulse_width: got %b expected 0", out_valid); end
  endtask

  task automatic test_wrap();
    logic [8:0] exp_h [4] = '{9'd350, 9'd355, 9'd359, 9'd2};
    logic [8:0] smp   [4] = '{9'd350, 9'd10, 9'd10, 9'd10};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send(smp[i], lat);
      n_cmp++; if (lat != 2) begin n_bad++; $display("FAIL wrap_latency[%0d]: got %0d expected 2", i, lat); end
      n_cmp++; if (heading_out !== exp_h[i]) begin n_bad++; $display("FAIL wrap_heading[%0d]: got %0d expected %0d", i, heading_out, exp_h[i]); end
      n_cmp++; if (cardinal !== 3'd0) begin n_bad++; $display("FAIL wrap_cardinal[%0d]: got %0d expected 0", i, cardinal); end
    end
  endtask

  task automatic test_half_turn();
    do_reset();
    send(9'd0, lat);
    n_cmp++; if (heading_out !== 9'd0) begin n_bad++; $display("FAIL half_load: got %0d expected 0", heading_out); end
    send(9'd180, lat);
    n_cmp++; if (lat != 2) begin n_bad++; $display("FAIL half_latency: got %0d expected 2", lat); end
    n_cmp++; if (heading_out !== 9'd45) begin n_bad++; $display("FAIL half_heading: got %0d expected 45", heading_out); end
    n_cmp++; if (cardinal !== 3'd1) begin n_bad++; $display("FAIL half_cardinal: got %0d expected 1", cardinal); end
  endtask

  task automatic test_invalid_overrun();
    do_reset();
    send(9'd100, lat);
    n_cmp++; if (heading_out !== 9'd100) begin n_bad++; $display("FAIL ovr_load: got %0d expected 100", heading_out); end
    heading_in = 9'd400;
    heading_valid = 1'b1;
    @(negedge clk);
    heading_valid = 1'b0;
    pulses = 0;
    repeat (4) begin @(negedge clk); if (out_valid) pulses++; end
    n_cmp++; if (pulses != 0) begin n_bad++; $display("FAIL invalid_pulses: got %0d expected 0", pulses); end
    n_cmp++; if (heading_out !== 9'd100) begin n_bad++; $display("FAIL invalid_heading: got %0d expected 100", heading_out); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL overrun_before: got %b expected 0", overrun); end
    heading_in = 9'd120;
    heading_valid = 1'b1;
    @(negedge clk);
    heading_in = 9'd300;
    @(negedge clk);
    heading_valid = 1'b0;
    n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL overrun_set: got %b expected 1", overrun); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL overrun_first_valid: got %b expected 1", out_valid); end
    n_cmp++; if (heading_out !== 9'd105) begin n_bad++; $display("FAIL overrun_heading: got %0d expected 105", heading_out); end
    pulses = 0;
    repeat (4) begin @(negedge clk); if (out_valid) pulses++; end
    n_cmp++; if (pulses != 0) begin n_bad++; $display("FAIL overrun_dropped: got %0d pulses expected 0", pulses); end
    n_cmp++; if (heading_out !== 9'd105) begin n_bad++; $display("FAIL overrun_hold: got %0d expected 105", heading_out); end
    n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL overrun_sticky: got %b expected 1", overrun); end
  endtask

  task automatic test_settle();
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      send(9'd45, lat);
      if (i == 8) begin
        n_cmp++; if (settled !== 1'b0) begin n_bad++; $display("FAIL settle_early: got %b expected 0", settled); end
      end
    end
    n_cmp++; if (settled !== 1'b1) begin n_bad++; $display("FAIL settle_ninth: got %b expected 1", settled); end
    n_cmp++; if (cardinal !== 3'd1) begin n_bad++; $display("FAIL settle_cardinal: got %0d expected 1", cardinal); end
    send(9'd47, lat);
    n_cmp++; if (heading_out !== 9'd46) begin n_bad++; $display("FAIL settle_small_heading: got %0d expected 46", heading_out); end
    n_cmp++; if (settled !== 1'b1) begin n_bad++; $display("FAIL settle_small_hold: got %b expected 1", settled); end
    send(9'd200, lat);
    n_cmp++; if (heading_out !== 9'd84) begin n_bad++; $display("FAIL settle_jump_heading: got %0d expected 84", heading_out); end
    n_cmp++; if (settled !== 1'b0) begin n_bad++; $display("FAIL settle_jump_clear: got %b expected 0", settled); end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 1; i <= 9; i++) send(9'd45, lat);
    n_cmp++; if (settled !== 1'b1) begin n_bad++; $display("FAIL tmo_pre_settled: got %b expected 1", settled); end
    // 45 accepted at edge t; here just after t+2.
    repeat (58) @(negedge clk);
    heading_in = 9'd400;
    heading_valid = 1'b1;
    @(negedge clk);
    heading_valid = 1'b0;
    repeat (34) @(negedge clk);
    n_cmp++; if (stale !== 1'b0) begin n_bad++; $display("FAIL tmo_early_stale: got %b expected 0", stale); end
    n_cmp++; if (settled !== 1'b1) begin n_bad++; $display("FAIL tmo_early_settled: got %b expected 1", settled); end
    repeat (6) @(negedge clk);
    n_cmp++; if (stale !== 1'b1) begin n_bad++; $display("FAIL tmo_stale: got %b expected 1", stale); end
    n_cmp++; if (settled !== 1'b0) begin n_bad++; $display("FAIL tmo_settled: got %b expected 0", settled); end
    send(9'd270, lat);
    n_cmp++; if (lat != 2) begin n_bad++; $display("FAIL tmo_reload_latency: got %0d expected 2", lat); end
    n_cmp++; if (heading_out !== 9'd270) begin n_bad++; $display("FAIL tmo_reload_heading: got %0d expected 270", heading_out); end
    n_cmp++; if (cardinal !== 3'd6) begin n_bad++; $display("FAIL tmo_reload_cardinal: got %0d expected 6", cardinal); end
    n_cmp++; if (stale !== 1'b0) begin n_bad++; $display("FAIL tmo_reload_stale: got %b expected 0", stale); end
  endtask

  task automatic test_reset_mid_calc();
    heading_in = 9'd90;
    heading_valid = 1'b1;
    @(negedge clk);
    heading_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_cmp++; if (heading_out !== 9'd0) begin n_bad++; $display("FAIL abort_heading: got %0d expected 0", heading_out); end
    n_cmp++; if (cardinal !== 3'd0) begin n_bad++; $display("FAIL abort_cardinal: got %0d expected 0", cardinal); end
    n_cmp++; if (stale !== 1'b1) begin n_bad++; $display("FAIL abort_stale: got %b expected 1", stale); end
    n_cmp++; if (settled !== 1'b0) begin n_bad++; $display("FAIL abort_settled: got %b expected 0", settled); end
    pulses = 0;
    repeat (4) begin @(negedge clk); if (out_valid) pulses++; end
    n_cmp++; if (pulses != 0) begin n_bad++; $display("FAIL abort_pulses: got %0d expected 0", pulses); end
    n_cmp++; if (heading_out !== 9'd0) begin n_bad++; $display("FAIL abort_hold: got %0d expected 0", heading_out); end
  endtask

  initial begin
    test_reset();
    test_first_sample();
    test_wrap();
    test_half_turn();
    test_invalid_overrun();
    test_settle();
    test_timeout();
    test_reset_mid_calc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
